oled_spi_tx: RTL and testbench
==============================

# oled_spi_tx

Parametrised SPI transmitter for SSD1306-class OLED panels, the next generation of the fixed OLED serial driver inside `DigitalSystem`. It owns the panel's hardware reset sequence, buffers command and data bytes in an internal FIFO, and shifts them out MSB-first on a 4-wire SPI bus with a configurable clock divider. Back-to-back bytes are sent as bursts with CS held low. It sits between the frame or command sequencer (upstream valid/ready) and the `OLED_*` pins.

## Interface
- `CLK_DIV`, 4: system cycles per `OLED_CLK` half-period. Must be ≥1.
- `FIFO_DEPTH`, 16: byte FIFO entries. Power of 2, ≥2.
- `RES_LOW_CYCLES`, 1000: cycles `OLED_RES` is held low during init.
- `RES_WAIT_CYCLES`, 1000: cycles after `OLED_RES` rises before the first byte may be sent.
- `CS_GAP_CYCLES`, 2: minimum cycles CS stays high between bursts. Must be ≥1.

- `CLK_100MHz` in 1: system clock. Single clock domain.
- `RST_N` in 1: asynchronous, active-low reset.
- `tx_data` in 8: byte to send.
- `tx_dc` in 1: 0 = command, 1 = display data. Driven on `OLED_D_C` for that byte.
- `tx_valid` in 1: byte offered.
- `tx_ready` out 1: FIFO not full. The byte is accepted on a rising edge when `tx_valid && tx_ready`.
- `reinit` in 1: single-cycle pulse that requests a new panel reset sequence.
- `init_done` out 1: high while the panel reset sequence is complete.
- `busy` out 1: high when the FSM is not in IDLE, or the FIFO is non-empty.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: number of entries held in the FIFO.
- `OLED_CLK`, `OLED_DIN`, `OLED_CS`, `OLED_D_C`, `OLED_RES` out 1 each: panel pins.

## Operation
- Reset values:
  - `OLED_RES`=0, `OLED_CS`=1, `OLED_CLK`=0, `OLED_DIN`=0, `OLED_D_C`=0.
  - `init_done`=0, `busy`=1, `fifo_level`=0, `tx_ready`=1.
  - FSM in RES_LO; FIFO empty.
- SPI mode 0: clock idles low, the panel samples on the rising edge, `OLED_DIN` changes only on falling edges or in LOAD. Bits are sent MSB first.
- FSM states:
  - **RES_LO**: `OLED_RES`=0 for `RES_LOW_CYCLES` cycles, then go to RES_HI.
  - **RES_HI**: `OLED_RES`=1 for `RES_WAIT_CYCLES` cycles, then go to IDLE and set `init_done`=1.
  - **IDLE**: if the FIFO is non-empty, go to LOAD. If a reinit is pending, go to RES_LO (pending reinit has priority).
  - **LOAD** (1 cycle): pop the FIFO head. Shift register ← data, `OLED_D_C` ← dc, `OLED_CS` ← 0, `OLED_DIN` ← bit7. Go to SHIFT.
  - **SHIFT**: 8 bits. Each bit is a low phase of `CLK_DIV` cycles followed by a high phase of `CLK_DIV` cycles. At each falling edge except the last, shift and drive the next bit. After the bit-0 high phase, `OLED_CLK` returns to 0:
    - FIFO non-empty and no pending reinit: go to LOAD (burst, CS stays low; D/C may change between bytes).
    - Otherwise: `OLED_CS` ← 1, go to GAP.
  - **GAP**: `CS_GAP_CYCLES` cycles with CS high, then go to IDLE.
- `reinit` is latched when it pulses in any state. It takes effect only at a byte boundary: from IDLE, or at the end of SHIFT via GAP → IDLE → RES_LO. Entering RES_LO clears `init_done` and the latch. FIFO contents are kept and sent after the new init.
- While in RES_LO or RES_HI, bytes are accepted into the FIFO but not sent.
- FIFO:
  - Full: `tx_ready`=0, and `tx_valid` is ignored.
  - Push and pop in the same cycle: `fifo_level` is unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`; the level counter distinguishes full from empty.
- `RST_N` asserted mid-byte aborts immediately. All outputs return to their reset values and the FIFO empties; there is no partial-byte completion.

## Timing
- Byte accepted at edge E (FIFO written) → IDLE sees non-empty at E+1 → LOAD. `OLED_CS` falls at edge E+2.
- First `OLED_CLK` rise comes `CLK_DIV` cycles after CS falls.
- One byte occupies 1 + 16·`CLK_DIV` cycles. In a burst, byte N+1's LOAD directly follows byte N's last high phase.
- CS rises on the edge that ends the last high phase. It stays high for ≥`CS_GAP_CYCLES` cycles.
- From reset release, `init_done` rises after `RES_LOW_CYCLES`+`RES_WAIT_CYCLES` cycles.
- `fifo_level` and `tx_ready` are registered and update on the edge after a push or pop.

## Structure
- Shared `oled_pkg`:
  - FSM state encodings.
  - SSD1306 command constants (e.g. DISPLAY_OFF 8'hAE, DISPLAY_ON 8'hAF, SET_CHARGE_PUMP 8'h8D) for upstream sequencers.
- Sub-module `oled_byte_fifo`: 9-bit wide (dc + data), `FIFO_DEPTH` deep, synchronous, with a level output.
- Top-level: FSM, divider counter, bit counter, shift register.

## Test plan
- Reset release with `RES_LOW_CYCLES`=10, `RES_WAIT_CYCLES`=10 → `OLED_RES` low for 10 cycles, high after; `init_done` rises at cycle 20. `OLED_CS`=1 and `OLED_CLK`=0 throughout.
- Single command 8'hAF, dc=0, `CLK_DIV`=2 → CS low for one byte, `OLED_D_C`=0. Bits sampled on rising edges are 1,0,1,0,1,1,1,1. Byte length is 33 cycles; then the gap.
- Burst of 3 data bytes 8'h01, 8'h80, 8'hFF pushed back-to-back → CS low continuously for 24 rising edges, `OLED_D_C`=1, serial bits match MSB-first.
- Fill FIFO with 16 bytes before `init_done` → `tx_ready`=0 and the 17th push is ignored. All 16 bytes are sent in order after init; `fifo_level` reaches 0.
- `reinit` pulsed mid-byte with 2 bytes queued → current byte completes, CS goes high, `init_done` drops, `OLED_RES` pulses low, then the 2 queued bytes are sent.
- `RST_N` low during bit 3 of a byte → outputs return to their reset values within the same cycle, `fifo_level`=0, and the init sequence restarts.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared definitions for the SSD1306 SPI transmitter and the sequencers that feed it.
package oled_pkg;

  typedef enum logic [2:0] {
    ST_RES_LO = 3'd0,
    ST_RES_HI = 3'd1,
    ST_IDLE   = 3'd2,
    ST_LOAD   = 3'd3,
    ST_SHIFT  = 3'd4,
    ST_GAP    = 3'd5
  } oled_state_e;

  // SSD1306 command bytes for upstream command sequencers
  localparam logic [7:0] SSD_SET_MEM_MODE    = 8'h20;
  localparam logic [7:0] SSD_SET_CONTRAST    = 8'h81;
  localparam logic [7:0] SSD_SET_CHARGE_PUMP = 8'h8D;
  localparam logic [7:0] SSD_NORMAL_DISPLAY  = 8'hA6;
  localparam logic [7:0] SSD_DISPLAY_OFF     = 8'hAE;
  localparam logic [7:0] SSD_DISPLAY_ON      = 8'hAF;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/oled_spi_tx_if.sv
// Byte handshake between the upstream sequencer and the OLED SPI transmitter.
interface oled_spi_tx_if;
  logic [7:0] tx_data;
  logic       tx_dc;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_dc, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_dc, input tx_valid, output tx_ready);
endinterface

// File: rtl/oled_byte_fifo.sv
// Synchronous FIFO of {dc, data} entries with a registered fill level.
module oled_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [8:0]             push_data,
  input  logic                   pop,
  output logic [8:0]             pop_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];
  assign level    = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // storage needs no reset: the level counter says what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/oled_spi_tx.sv
// SSD1306 4-wire SPI transmitter: panel reset sequencing, byte FIFO, mode-0 shifter.
//
// state    | meaning
// RES_LO   | OLED_RES held low
// RES_HI   | OLED_RES high, waiting before the first byte
// IDLE     | panel ready, waiting for a byte or a pending reinit
// LOAD     | pop FIFO head into the shifter, CS low
// SHIFT    | 8 bits, each a low then a high OLED_CLK phase
// GAP      | CS high for the minimum inter-burst gap
module oled_spi_tx
  import oled_pkg::*;
#(
  parameter int CLK_DIV         = 4,
  parameter int FIFO_DEPTH      = 16,
  parameter int RES_LOW_CYCLES  = 1000,
  parameter int RES_WAIT_CYCLES = 1000,
  parameter int CS_GAP_CYCLES   = 2
) (
  input  logic                        CLK_100MHz,
  input  logic                        RST_N,
  oled_spi_tx_if.slave                tx_if,
  input  logic                        reinit,
  output logic                        init_done,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        OLED_CLK,
  output logic                        OLED_DIN,
  output logic                        OLED_CS,
  output logic                        OLED_D_C,
  output logic                        OLED_RES
);
  localparam int TMAX = max4(CLK_DIV, RES_LOW_CYCLES, RES_WAIT_CYCLES, CS_GAP_CYCLES);
  localparam int TW   = $clog2(TMAX) + 1;

  localparam logic [TW-1:0] DIV_LOAD  = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] RES_LOAD  = TW'(RES_LOW_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LOAD = TW'(RES_WAIT_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(CS_GAP_CYCLES - 1);

  oled_state_e   state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d, tmr_dec;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sreg_q, sreg_d;
  logic          sclk_q, sclk_d;
  logic          cs_q, cs_d;
  logic          dc_q, dc_d;
  logic          pend_q, pend_d, pend_now;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [8:0]    fifo_head;

  oled_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (CLK_100MHz),
    .rst_n     (RST_N),
    .push      (tx_if.tx_valid),
    .push_data ({tx_if.tx_dc, tx_if.tx_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign tx_if.tx_ready = !fifo_full;
  assign tmr_dec        = tmr_q - TW'(1);
  assign pend_now       = pend_q || reinit;

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    bit_d    = bit_q;
    sreg_d   = sreg_q;
    sclk_d   = sclk_q;
    cs_d     = cs_q;
    dc_d     = dc_q;
    pend_d   = pend_now;
    fifo_pop = 1'b0;
    case (state_q)
      ST_RES_LO: begin
        if (tmr_q == '0) begin
          state_d = ST_RES_HI;
          tmr_d   = WAIT_LOAD;
        end else begin
          tmr_d = tmr_dec;
        end
      end
      ST_RES_HI: begin
        if (tmr_q == '0) state_d = ST_IDLE;
        else             tmr_d   = tmr_dec;
      end
      ST_IDLE: begin
        if (pend_now) begin
          state_d = ST_RES_LO;
          tmr_d   = RES_LOAD;
          pend_d  = 1'b0;
        end else if (!fifo_empty) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        fifo_pop = 1'b1;
        sreg_d   = fifo_head[7:0];
        dc_d     = fifo_head[8];
        cs_d     = 1'b0;
        sclk_d   = 1'b0;
        bit_d    = 3'd7;
        tmr_d    = DIV_LOAD;
        state_d  = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_dec;
        end else begin
          tmr_d = DIV_LOAD;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q != 3'd0) begin
              bit_d  = bit_q - 3'd1;
              sreg_d = {sreg_q[6:0], 1'b0};
            end else if (!fifo_empty && !pend_now) begin
              state_d = ST_LOAD;
            end else begin
              cs_d    = 1'b1;
              tmr_d   = GAP_LOAD;
              state_d = ST_GAP;
            end
          end
        end
      end
      ST_GAP: begin
        if (tmr_q == '0) state_d = ST_IDLE;
        else             tmr_d   = tmr_dec;
      end
      default: begin
        state_d = ST_RES_LO;
        tmr_d   = RES_LOAD;
      end
    endcase
  end

  always_ff @(posedge CLK_100MHz or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_RES_LO;
      tmr_q   <= RES_LOAD;
      bit_q   <= 3'd0;
      sreg_q  <= 8'd0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      dc_q    <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      dc_q    <= dc_d;
      pend_q  <= pend_d;
    end
  end

  assign OLED_CLK  = sclk_q;
  assign OLED_DIN  = sreg_q[7];
  assign OLED_CS   = cs_q;
  assign OLED_D_C  = dc_q;
  assign OLED_RES  = (state_q != ST_RES_LO);
  assign init_done = (state_q != ST_RES_LO) && (state_q != ST_RES_HI);
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_oled_spi_tx.sv
// Directed and randomized bench for oled_spi_tx with a serial-bus byte monitor.
module tb_oled_spi_tx;
  localparam int CLK_DIV = 2;
  localparam int DEPTH   = 16;
  localparam int RES_LOW = 10;
  localparam int RES_WT  = 10;
  localparam int CS_GAP  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       reinit = 1'b0;
  logic       init_done, busy;
  logic [4:0] fifo_level;
  logic       oled_clk, oled_din, oled_cs, oled_dc, oled_res;

  oled_spi_tx_if tx_if ();

  oled_spi_tx #(
    .CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH), .RES_LOW_CYCLES(RES_LOW),
    .RES_WAIT_CYCLES(RES_WT), .CS_GAP_CYCLES(CS_GAP)
  ) dut (
    .CLK_100MHz(clk), .RST_N(rst_n), .tx_if(tx_if), .reinit(reinit),
    .init_done(init_done), .busy(busy), .fifo_level(fifo_level),
    .OLED_CLK(oled_clk), .OLED_DIN(oled_din), .OLED_CS(oled_cs),
    .OLED_D_C(oled_dc), .OLED_RES(oled_res)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference: bytes the panel must receive, in order, as {dc, data}
  logic [8:0] exp_q[$];

  logic [7:0] mon_sh = 8'd0;
  int mon_bits = 0, mon_edges = 0, last_burst_edges = 0, bytes_done = 0;
  int high_cnt = 0, min_gap = 1000, viol_rise = 0, viol_din = 0;
  logic prev_clk = 1'b0, prev_din = 1'b0, prev_cs = 1'b1, gap_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // the panel's view: sample DIN on every OLED_CLK rise while CS is low
  always @(negedge clk) begin
    logic [7:0] b;
    logic [8:0] e;
    if (!rst_n) begin
      mon_bits = 0; mon_edges = 0; gap_valid = 1'b0; high_cnt = 0;
      prev_clk = 1'b0; prev_cs = 1'b1; prev_din = 1'b0;
    end else begin
      if (oled_clk && !prev_clk) begin
        if (oled_cs || !init_done) viol_rise++;
        b = {mon_sh[6:0], oled_din};
        mon_sh = b;
        mon_bits++;
        mon_edges++;
        if (mon_bits == 8) begin
          mon_bits = 0;
          bytes_done++;
          check("byte_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("byte_data", b, e[7:0]);
            check("byte_dc", oled_dc, e[8]);
          end
        end
      end
      if (oled_clk && prev_clk && oled_din !== prev_din) viol_din++;
      if (oled_cs && !prev_cs) begin
        last_burst_edges = mon_edges;
        mon_edges = 0;
        high_cnt = 0;
        gap_valid = 1'b1;
      end
      if (!oled_cs && prev_cs && gap_valid && high_cnt < min_gap) min_gap = high_cnt;
      if (oled_cs) high_cnt++;
      prev_clk = oled_clk;
      prev_cs  = oled_cs;
      prev_din = oled_din;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic dc);
    tx_if.tx_data  = d;
    tx_if.tx_dc    = dc;
    tx_if.tx_valid = 1'b1;
    for (int i = 0; i < 2000 && !tx_if.tx_ready; i++) tick();
    check("push_ready", tx_if.tx_ready, 1);
    @(posedge clk);
    exp_q.push_back({dc, d});
    #1;
    tx_if.tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int i;
    for (i = 0; i < 5000; i++) begin
      if (!busy && exp_q.size() == 0) break;
      tick();
    end
    check(tag, 32'(i < 5000), 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_res"},   oled_res, 0);
    check({tag, "_cs"},    oled_cs, 1);
    check({tag, "_sclk"},  oled_clk, 0);
    check({tag, "_din"},   oled_din, 0);
    check({tag, "_dc"},    oled_dc, 0);
    check({tag, "_init"},  init_done, 0);
    check({tag, "_busy"},  busy, 1);
    check({tag, "_level"}, fifo_level, 0);
    check({tag, "_ready"}, tx_if.tx_ready, 1);
  endtask

  task automatic release_and_check_init(input string tag);
    int bad;
    bad = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      tick();
      if (oled_cs !== 1'b1 || oled_clk !== 1'b0) bad++;
      if (k == RES_LOW - 1)      check({tag, "_res_still_low"}, oled_res, 0);
      if (k == RES_LOW)          check({tag, "_res_high"}, oled_res, 1);
      if (k == RES_LOW + RES_WT - 1) check({tag, "_init_not_yet"}, init_done, 0);
      if (k == RES_LOW + RES_WT) check({tag, "_init_done"}, init_done, 1);
    end
    check({tag, "_bus_quiet"}, bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n, cnt, first, bd0;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'd0;
    tx_if.tx_dc    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    release_and_check_init("init");

    // single command byte, latency and length
    push(8'hAF, 1'b0);
    tick(); check("cs_high_e1", oled_cs, 1);
    tick(); check("cs_low_e2", oled_cs, 0);
    check("dc_cmd", oled_dc, 0);
    first = 0;
    cnt = 0;
    while (cnt < 200) begin
      tick();
      cnt++;
      if (oled_clk && first == 0) first = cnt;
      if (oled_cs) break;
    end
    check("first_rise", first, CLK_DIV);
    check("cs_low_len", cnt, 16 * CLK_DIV);
    wait_idle("single_idle");
    check("single_edges", last_burst_edges, 8);

    push(8'h01, 1'b1); push(8'h80, 1'b1); push(8'hFF, 1'b1);
    wait_idle("burst_idle");
    check("burst_edges", last_burst_edges, 24);

    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) begin
        push(8'($urandom), 1'($urandom));
        repeat ($urandom_range(0, 40)) tick();
      end
      wait_idle("rand_idle");
    end

    // fill the FIFO while the panel is still in reset
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < DEPTH; j++) push(8'($urandom), 1'($urandom));
    check("fill_level", fifo_level, DEPTH);
    check("fill_ready", tx_if.tx_ready, 0);
    check("fill_not_init", init_done, 0);
    tx_if.tx_data = 8'h5A; tx_if.tx_dc = 1'b1; tx_if.tx_valid = 1'b1;
    tick(); tick();
    tx_if.tx_valid = 1'b0;
    check("overflow_level", fifo_level, DEPTH);
    wait_idle("fill_idle");
    check("fill_drained", fifo_level, 0);
    check("fill_edges", last_burst_edges, 8 * DEPTH);

    // reinit requested mid-byte with two bytes queued
    for (int j = 0; j < 3; j++) push(8'($urandom), 1'($urandom));
    cnt = 0;
    while (mon_bits < 2 && cnt < 500) begin tick(); cnt++; end
    check("reinit_mid_byte", 32'(mon_bits >= 2), 1);
    bd0 = bytes_done;
    reinit = 1'b1;
    tick();
    reinit = 1'b0;
    cnt = 0;
    while (init_done && cnt < 500) begin tick(); cnt++; end
    check("reinit_drop", init_done, 0);
    check("reinit_one_byte", bytes_done, bd0 + 1);
    check("reinit_res_low", oled_res, 0);
    check("reinit_cs_high", oled_cs, 1);
    check("reinit_level", fifo_level, 2);
    wait_idle("reinit_idle");
    check("reinit_done_again", init_done, 1);

    // reset asserted during bit 3 of a byte
    push(8'($urandom), 1'($urandom));
    push(8'($urandom), 1'($urandom));
    cnt = 0;
    while (mon_bits < 3 && cnt < 500) begin tick(); cnt++; end
    check("abort_mid_byte", mon_bits, 3);
    rst_n = 1'b0;
    #1;
    check_reset_vals("abort");
    exp_q.delete();
    repeat (2) tick();
    release_and_check_init("restart");

    n = $urandom_range(2, 5);
    for (int j = 0; j < n; j++) push(8'($urandom), 1'($urandom));
    wait_idle("post_restart_idle");

    check("rise_outside_cs_or_init", viol_rise, 0);
    check("din_change_while_high", viol_din, 0);
    check("cs_gap_min", 32'(min_gap >= CS_GAP && min_gap < 1000), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
